alu_multicycle: RTL and testbench

- Execution-stage ALU that consumes the 3-bit ALU control code produced by the ALU control decoder and returns a registered result.
- Logic ops, add, sub and slt complete in one cycle. Multiply runs as an iterative shift-add sequence over WIDTH cycles.
- A start/busy/done handshake lets the pipeline stall on multiplies.

---
 rtl/alu_multicycle_if.sv | 24 ++
 rtl/alu_multicycle.sv | 126 ++++++++++++
 tb/tb_alu_multicycle.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_multicycle_if.sv
// Handshake and operand/result bundle between the pipeline and alu_multicycle.
// master = pipeline side, slave = ALU side.
interface alu_multicycle_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [2:0]       ALUCtrl_i;
    logic [WIDTH-1:0] data1_i;
    logic [WIDTH-1:0] data2_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] data_o;
    logic             zero_o;

    modport master (
        output start_i, ALUCtrl_i, data1_i, data2_i,
        input  busy_o, done_o, data_o, zero_o
    );

    modport slave (
        input  start_i, ALUCtrl_i, data1_i, data2_i,
        output busy_o, done_o, data_o, zero_o
    );
endinterface

// File: rtl/alu_multicycle.sv
// Execution-stage ALU: single-cycle logic/arith ops, iterative shift-add multiply.
// Define ALU_MUL_EARLY_TERM_EN to finish a multiply once the remaining multiplier bits are zero.
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    alu_multicycle_if.slave   alu
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {S_IDLE, S_MUL} state_e;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_MUL = 3'b100,
        OP_SUB = 3'b110,
        OP_SLT = 3'b111
    } alu_op_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] mplier_next;
    logic             mul_last;

    always_comb begin
        alu_res = '0;
        case (alu_op_e'(alu.ALUCtrl_i))
            OP_AND:  alu_res = alu.data1_i & alu.data2_i;
            OP_OR:   alu_res = alu.data1_i | alu.data2_i;
            OP_ADD:  alu_res = alu.data1_i + alu.data2_i;
            OP_SUB:  alu_res = alu.data1_i - alu.data2_i;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(alu.data1_i) < $signed(alu.data2_i))};
            default: alu_res = '0;
        endcase
    end

    assign acc_next    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign mplier_next = mplier_q >> 1;

`ifdef ALU_MUL_EARLY_TERM_EN
    assign mul_last = (cnt_q == CW'(1)) || (mplier_next == '0);
`else
    assign mul_last = (cnt_q == CW'(1));
`endif

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        zero_d   = zero_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (alu.start_i) begin
                    if (alu.ALUCtrl_i == OP_MUL) begin
                        mcand_d  = alu.data1_i;
                        mplier_d = alu.data2_i;
                        acc_d    = '0;
                        cnt_d    = CW'(WIDTH);
                        state_d  = S_MUL;
                    end else begin
                        data_d = alu_res;
                        zero_d = (alu_res == '0);
                        done_d = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_next;
                cnt_d    = cnt_q - CW'(1);
                if (mul_last) begin
                    data_d  = acc_next;
                    zero_d  = (acc_next == '0);
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

    assign alu.busy_o = (state_q == S_MUL);
    assign alu.done_o = done_q;
    assign alu.data_o = data_q;
    assign alu.zero_o = zero_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle (both multiply latency builds).
module tb_alu_multicycle;
    localparam int W = 32;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   done_cnt;
    int   base;
    int   lat;
    int   busy_n;
    int   exp_lat;

    alu_multicycle_if #(.WIDTH(W)) bus ();

    alu_multicycle #(.WIDTH(W)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .alu   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (bus.done_o === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present a request for exactly one rising edge; returns #1 after that edge.
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start_i   = 1'b1;
        bus.ALUCtrl_i = op;
        bus.data1_i   = a;
        bus.data2_i   = b;
        @(posedge clk);
        #1;
        bus.start_i   = 1'b0;
        bus.ALUCtrl_i = 3'b001;
        bus.data1_i   = 32'hDEAD_BEEF;
        bus.data2_i   = 32'h1234_5678;
    endtask

    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
        start_op(op, a, b);
        chk({tag, "_done"}, 32'(bus.done_o), 32'd1);
        chk({tag, "_data"}, bus.data_o, exp);
        chk({tag, "_zero"}, 32'(bus.zero_o), 32'(exp == 32'd0));
        chk({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_done_drop"}, 32'(bus.done_o), 32'd0);
        chk({tag, "_hold"}, bus.data_o, exp);
    endtask

    // Called #1 after the accepting edge; n = cycles until done_o seen.
    task automatic wait_done(output int n, output int bn);
        n  = 0;
        bn = (bus.busy_o === 1'b1) ? 1 : 0;
        while (bus.done_o !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.done_o !== 1'b1 && bus.busy_o === 1'b1) bn++;
        end
    endtask

    task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int elat);
        start_op(3'b100, a, b);
        chk({tag, "_busy_start"}, 32'(bus.busy_o), 32'd1);
        chk({tag, "_done_start"}, 32'(bus.done_o), 32'd0);
        wait_done(lat, busy_n);
        chk({tag, "_latency"}, 32'(lat), 32'(elat));
        chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(elat));
        chk({tag, "_busy_end"}, 32'(bus.busy_o), 32'd0);
        chk({tag, "_data"}, bus.data_o, exp);
        chk({tag, "_zero"}, 32'(bus.zero_o), 32'(exp == 32'd0));
        @(posedge clk);
        #1;
        chk({tag, "_done_drop"}, 32'(bus.done_o), 32'd0);
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        done_cnt      = 0;
        rst_n         = 1'b0;
        bus.start_i   = 1'b0;
        bus.ALUCtrl_i = 3'b000;
        bus.data1_i   = '0;
        bus.data2_i   = '0;

        #12;
        chk("rst_data", bus.data_o, 32'd0);
        chk("rst_zero", 32'(bus.zero_o), 32'd1);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_done", 32'(bus.done_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("idle_no_done", 32'(done_cnt), 32'd0);

        do_op("add", 3'b010, 32'd5, 32'd3, 32'd8);

        // asynchronous reset asserted mid-cycle
        #2 rst_n = 1'b0;
        #1;
        chk("arst_data", bus.data_o, 32'd0);
        chk("arst_zero", 32'(bus.zero_o), 32'd1);
        chk("arst_busy", 32'(bus.busy_o), 32'd0);
        chk("arst_done", 32'(bus.done_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        base = done_cnt;
        repeat (5) @(posedge clk);
        #1;
        chk("arst_no_done", 32'(done_cnt - base), 32'd0);

        do_op("add2", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'd1);
        do_op("sub", 3'b110, 32'd9, 32'd9, 32'd0);
        do_op("sub_wrap", 3'b110, 32'd3, 32'd5, 32'hFFFF_FFFE);
        do_op("and", 3'b000, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
        do_op("or", 3'b001, 32'hF000_0001, 32'h0000_0F10, 32'hF000_0F11);
        do_op("slt_neg", 3'b111, 32'hFFFF_FFFF, 32'd1, 32'd1);
        do_op("slt_pos", 3'b111, 32'd1, 32'hFFFF_FFFF, 32'd0);
        do_op("undef011", 3'b011, 32'd7, 32'd9, 32'd0);
        do_op("slt_eq", 3'b111, 32'd4, 32'd4, 32'd0);
        do_op("undef101", 3'b101, 32'd7, 32'd9, 32'd0);

`ifdef ALU_MUL_EARLY_TERM_EN
        exp_lat = 3;
`else
        exp_lat = 32;
`endif
        do_mul("mul_7x6", 32'd7, 32'd6, 32'd42, exp_lat);
`ifdef ALU_MUL_EARLY_TERM_EN
        exp_lat = 2;
`endif
        do_mul("mul_max", 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, exp_lat);
`ifdef ALU_MUL_EARLY_TERM_EN
        exp_lat = 1;
`endif
        do_mul("mul_by0", 32'd7, 32'd0, 32'd0, exp_lat);
        do_mul("mul_msb", 32'd3, 32'h8000_0001, 32'h8000_0003, 32);

        // start while busy must be ignored
        base = done_cnt;
        start_op(3'b100, 32'd3, 32'h8000_0001);
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.start_i   = 1'b1;
        bus.ALUCtrl_i = 3'b010;
        bus.data1_i   = 32'd1;
        bus.data2_i   = 32'd1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        chk("rej_busy", 32'(bus.busy_o), 32'd1);
        chk("rej_no_done", 32'(bus.done_o), 32'd0);
        wait_done(lat, busy_n);
        chk("rej_latency", 32'(lat), 32'd27);
        chk("rej_data", bus.data_o, 32'h8000_0003);
        repeat (4) @(posedge clk);
        #1;
        chk("rej_one_done", 32'(done_cnt - base), 32'd1);
        chk("rej_hold", bus.data_o, 32'h8000_0003);

        // back-to-back: new request in the done cycle
        base = done_cnt;
        start_op(3'b100, 32'd3, 32'd4);
        wait_done(lat, busy_n);
        chk("b2b_mul_data", bus.data_o, 32'd12);
        bus.start_i   = 1'b1;
        bus.ALUCtrl_i = 3'b010;
        bus.data1_i   = 32'd10;
        bus.data2_i   = 32'd20;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        chk("b2b_add_done", 32'(bus.done_o), 32'd1);
        chk("b2b_add_data", bus.data_o, 32'd30);
        repeat (3) @(posedge clk);
        #1;
        chk("b2b_two_done", 32'(done_cnt - base), 32'd2);

        // reset in the middle of a multiply
        base = done_cnt;
        start_op(3'b100, 32'd3, 32'h8000_0001);
        repeat (9) @(posedge clk);
        #1;
        chk("mrst_busy_before", 32'(bus.busy_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_busy", 32'(bus.busy_o), 32'd0);
        chk("mrst_data", bus.data_o, 32'd0);
        chk("mrst_zero", 32'(bus.zero_o), 32'd1);
        chk("mrst_done", 32'(bus.done_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("mrst_no_done", 32'(done_cnt - base), 32'd0);
        chk("mrst_idle", 32'(bus.busy_o), 32'd0);
        do_op("mrst_add", 3'b010, 32'd2, 32'd2, 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
